// File: rtl/mul16_seq_pkg.sv
// rtl/mul16_seq_pkg.sv - shared constants and state encoding for the sequential multiplier
package mul16_seq_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul16_seq_add16.sv
// rtl/mul16_seq_add16.sv - 16-bit adder without carry-out, shared by all multiply iterations
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mul16_seq.sv
// rtl/mul16_seq.sv - 16x16 unsigned shift-and-add multiplier, one iteration per clock
module mul16_seq
  import mul16_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] s;
  logic             c;
  logic [WIDTH-1:0] acc_hi_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic             last_iter;

  add16 u_add16 (
    .a   (acc_hi),
    .b   (mcand),
    .sum (s)
  );

  // The adder has no carry-out, so the carry is recovered from unsigned wraparound.
  always_comb begin
    c          = (s < acc_hi);
    acc_hi_nxt = {1'b0, acc_hi[WIDTH-1:1]};
    mplier_nxt = {acc_hi[0], mplier[WIDTH-1:1]};
    if (mplier[0]) begin
      acc_hi_nxt = {c, s[WIDTH-1:1]};
      mplier_nxt = {s[0], mplier[WIDTH-1:1]};
    end
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN) || (state == S_DONE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc_hi  <= '0;
      mplier  <= '0;
      mcand   <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          // product is left alone so the previous result stays readable.
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        S_RUN: begin
          acc_hi <= acc_hi_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) product <= {acc_hi_nxt, mplier_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// tb/tb_mul16_seq.sv - directed self-checking bench for mul16_seq
module tb_mul16_seq;
  import mul16_seq_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   a = '0;
  logic [WIDTH-1:0]   b = '0;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int checks = 0;
  int errors = 0;

  mul16_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Launches one multiply and follows it to the end; poke>0 pulses start with a=2,b=2 at that cycle.
  task automatic mul_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic [31:0] exp, input int poke);
    int busy_n;
    int done_n;
    int done_at;
    logic [31:0] prod;
    busy_n = 0; done_n = 0; done_at = 0; prod = '0;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = i;
        prod = product;
      end
      if (!busy) break;
      if (i == poke) begin
        a = 16'd2; b = 16'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd17);
    check({tag, "_done_count"}, 32'(done_n), 32'd1);
    check({tag, "_done_cycle"}, 32'(done_at), 32'd17);
    check({tag, "_product"}, prod, exp);
    check({tag, "_product_held"}, product, exp);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] exp_p;
    logic [31:0] prev_p;
    int          dn;
    bit          got;
    bit          held_ok;

    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", product, 32'd0);
    rst = 1'b0;
    start = 1'b0;

    mul_op("basic", 16'd3, 16'd5, 32'd15, 0);
    mul_op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
    mul_op("zero", 16'd0, 16'h1234, 32'd0, 0);
    mul_op("ident", 16'h1234, 16'd1, 32'h00001234, 0);
    mul_op("busy_start", 16'd7, 16'd9, 32'd63, 5);
    mul_op("alt_bits", 16'hAAAA, 16'h5555, 32'h38E31C72, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    a = 16'd100; b = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_product", product, 32'd0);
    rst = 1'b0;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("midrst_no_done", 32'(dn), 32'd0);
    mul_op("after_rst", 16'd100, 16'd200, 32'd20000, 0);

    // Back-to-back with start held high
    prev_p = 32'd20000;
    @(negedge clk);
    ra = 16'($urandom); rb = 16'($urandom);
    a = ra; b = rb; start = 1'b1;
    exp_p = {16'd0, ra} * {16'd0, rb};
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      held_ok = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
        @(negedge clk);
        if (done) begin
          check($sformatf("b2b%0d_product", k), product, exp_p);
          got = 1'b1;
          prev_p = exp_p;
          ra = 16'($urandom); rb = 16'($urandom);
          a = ra; b = rb;
          exp_p = {16'd0, ra} * {16'd0, rb};
          break;
        end else if (product !== prev_p) begin
          held_ok = 1'b0;
        end
      end
      check($sformatf("b2b%0d_done_seen", k), 32'(got), 32'd1);
      check($sformatf("b2b%0d_held", k), 32'(held_ok), 32'd1);
    end
    start = 1'b0;
    repeat (25) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
